cd_ram_drain: RTL and testbench
===============================

CD_RAM_DRAIN -- requirements
Module: cd_ram_drain

Interface
REQ-001 The block SHALL have parameter A_WIDTH, default 8, giving the page address width (page size 2**A_WIDTH bytes).
REQ-002 The block SHALL have parameter HDR_LEN_IDX, default 2, giving the page byte offset of the payload-length field.
REQ-003 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port unread, input, 1 bit, high while at least one page is filled and unread.
REQ-006 The block SHALL have ports rd_addr (output, A_WIDTH bits, read address) and rd_en (output, 1 bit, read strobe).
REQ-007 The block SHALL have ports rd_byte and rd_flags, inputs, 8 bits each, valid one cycle after rd_en.
REQ-008 The block SHALL have ports rd_done and rd_done_all, outputs, 1 bit each, one-cycle pulses: release current page / flush all pages.
REQ-009 The block SHALL have ports m_data (output, 8 bits), m_valid (output, 1 bit) and m_ready (input, 1 bit), forming the byte stream.
REQ-010 The block SHALL have ports m_last (output, 1 bit, last byte of frame) and m_flags (output, 8 bits, page flags, stable for the whole frame).
REQ-011 The block SHALL have port m_trunc, output, 1 bit, high for the whole frame when the length was clamped.
REQ-012 The block SHALL have port abort, input, 1 bit, host request to drop all pending pages.

Function
REQ-013 The FSM SHALL have states IDLE, HDR, STREAM, RELEASE and FLUSH.
REQ-014 IDLE: when unread=1, the block SHALL issue rd_en with rd_addr=HDR_LEN_IDX and go to HDR.
REQ-015 HDR (data cycle): the block SHALL latch the frame total = rd_byte+HDR_LEN_IDX+1, computed at A_WIDTH+1 bits, and latch m_flags from rd_flags.
REQ-016 HDR: if total > 2**A_WIDTH, the block SHALL clamp total to 2**A_WIDTH and set m_trunc=1.
REQ-017 HDR: the block SHALL then go to STREAM with read pointer 0.
REQ-018 STREAM: the block SHALL issue rd_en for addresses 0..total-1 in order, one per cycle, only while free skid capacity exists.
REQ-019 The block SHALL use a 2-entry skid buffer for 1-cycle RAM latency, sustaining 1 byte/cycle while m_ready=1.
REQ-020 m_data and m_valid SHALL come from the skid head; a byte transfers when m_valid and m_ready are both 1.
REQ-021 m_data and m_last SHALL be held stable while m_valid=1 and m_ready=0.
REQ-022 m_last SHALL be 1 exactly on byte total-1.
REQ-023 When the m_last byte transfers, the block SHALL pulse rd_done for one cycle (RELEASE) and return to IDLE.
REQ-024 After RELEASE, the next page SHALL start no earlier than the following cycle; back-to-back pages SHALL have at most 3 idle cycles between m_last and the next first byte.
REQ-025 abort in any state SHALL move the FSM to FLUSH, pulse rd_done_all once, empty the skid, drop m_valid next cycle, and return to IDLE.
REQ-026 abort SHALL take priority over a simultaneous m_last transfer; rd_done SHALL NOT pulse in that cycle.
REQ-027 rd_en SHALL never be asserted in IDLE without unread=1, nor in RELEASE or FLUSH.
REQ-028 rd_done and rd_done_all SHALL never be asserted in the same cycle.
REQ-029 A total of 2**A_WIDTH SHALL stream all addresses; the read pointer SHALL NOT wrap to 0 mid-frame.

Reset
REQ-030 On reset_n=0 the block SHALL asynchronously enter IDLE with skid empty and pointer 0.
REQ-031 On reset all outputs (rd_en, rd_done, rd_done_all, m_valid, m_last, m_trunc) SHALL be 0; m_flags, m_data and rd_addr SHALL be 0.
REQ-032 Reset mid-frame SHALL discard the frame with no rd_done pulse.

Structure
REQ-033 State encodings and the HDR_LEN_IDX default SHALL live in a shared package cd_pkg.
REQ-034 The skid buffer SHALL be one sub-module, cd_skid2, parameterised on data width (8+1 for data plus last).

Verification
REQ-035 Bench: page len byte=4, flags=0x5A, m_ready=1 -> 7 bytes, addr 0..6, 1/cycle, m_last on 7th, m_flags=0x5A, one rd_done.
REQ-036 Bench: same page, m_ready toggling 1-0-1-0 -> bytes in order, none lost or duplicated, data held while stalled.
REQ-037 Bench: A_WIDTH=8, len byte=0xFF -> m_trunc=1, 256 bytes, m_last on address 0xFF.
REQ-038 Bench: two pages queued, unread stays 1 -> two frames, two rd_done pulses, gap at most 3 cycles.
REQ-039 Bench: abort on 3rd byte of frame -> one rd_done_all, m_valid=0 next cycle, no rd_done, FSM in IDLE.
REQ-040 Bench: reset_n low during STREAM -> all outputs 0 immediately; after release with unread=1, a fresh header read at HDR_LEN_IDX.

Source files
------------

// File: rtl/cd_pkg.sv
// cd_ram_drain shared definitions
// FSM encoding, header defaults and skid entry width
package cd_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_STREAM  = 3'd2,
        S_RELEASE = 3'd3,
        S_FLUSH   = 3'd4
    } cd_state_e;

    localparam int HDR_LEN_IDX_DEF = 2;
    localparam int SKID_W          = 9;

endpackage

// File: rtl/cd_ram_drain_if.sv
// cd_ram_drain byte-stream interface
// master drives the frame bytes, slave applies backpressure
interface cd_ram_drain_if;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic [7:0] m_flags;
    logic       m_trunc;

    modport master (
        output m_data, m_valid, m_last, m_flags, m_trunc,
        input  m_ready
    );

    modport slave (
        input  m_data, m_valid, m_last, m_flags, m_trunc,
        output m_ready
    );

endinterface

// File: rtl/cd_skid2.sv
// cd_skid2: two-entry fall-through skid buffer
// an empty buffer presents the incoming word in the same cycle
module cd_skid2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] dout_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem0_q, mem0_d;
    logic [W-1:0] mem1_q, mem1_d;
    logic [1:0]   count_q, count_d;
    logic         pop;

    assign valid_o = (count_q != 2'd0) || push_i;
    assign dout_o  = (count_q != 2'd0) ? mem0_q :
                     (push_i ? din_i : '0);
    assign pop     = valid_o && ready_i;
    assign count_o = count_q;

    // append pushed word, drop head on pop, flush empties everything
    always_comb begin
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push_i && !pop) begin
                        mem0_d  = din_i;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (pop && push_i) begin
                        mem0_d = din_i;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end else if (push_i) begin
                        mem1_d  = din_i;
                        count_d = 2'd2;
                    end
                end
                default: begin
                    if (pop) begin
                        mem0_d = mem1_q;
                        if (push_i) begin
                            mem1_d = din_i;
                        end else begin
                            count_d = 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    // storage and occupancy registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cd_ram_drain.sv
// cd_ram_drain: streams filled RAM pages out as byte frames
// header length read first, then bytes 0..total-1 through a skid
module cd_ram_drain
    import cd_pkg::*;
#(
    parameter int A_WIDTH     = 8,
    parameter int HDR_LEN_IDX = HDR_LEN_IDX_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               unread,
    output logic [A_WIDTH-1:0] rd_addr,
    output logic               rd_en,
    input  logic [7:0]         rd_byte,
    input  logic [7:0]         rd_flags,
    output logic               rd_done,
    output logic               rd_done_all,
    input  logic               abort,
    cd_ram_drain_if.master     m
);

    localparam int TW = A_WIDTH + 1;
    localparam int SW = (A_WIDTH > 8) ? A_WIDTH + 2 : 10;
    localparam logic [TW-1:0] PAGE = TW'(1) << A_WIDTH;

    cd_state_e        state_q, state_d;
    logic [TW-1:0]    ptr_q, ptr_d;
    logic [TW-1:0]    total_q, total_d;
    logic [7:0]       flags_q, flags_d;
    logic             trunc_q, trunc_d;
    logic             infl_q, infl_d;
    logic             infl_last_q, infl_last_d;

    logic [SW-1:0]    sum;
    logic             clamp;
    logic [TW-1:0]    hdr_total;
    logic             rd_en_c;
    logic [A_WIDTH-1:0] addr_c;
    logic             flush;
    logic             pop;
    logic [SKID_W-1:0] skid_dout;
    logic             skid_valid;
    logic [1:0]       skid_cnt;
    logic [2:0]       occ;

    assign sum       = SW'(rd_byte) + SW'(HDR_LEN_IDX) + SW'(1);
    assign clamp     = sum > SW'(PAGE);
    assign hdr_total = clamp ? PAGE : sum[TW-1:0];
    assign pop       = skid_valid && m.m_ready;
    assign occ       = 3'(skid_cnt) + 3'(infl_q) - 3'(pop);

    // state sequencing, read issue and release strobes
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        total_d     = total_q;
        flags_d     = flags_q;
        trunc_d     = trunc_q;
        infl_d      = 1'b0;
        infl_last_d = 1'b0;
        rd_en_c     = 1'b0;
        addr_c      = '0;
        rd_done     = 1'b0;
        rd_done_all = 1'b0;
        flush       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (unread) begin
                    rd_en_c = 1'b1;
                    addr_c  = A_WIDTH'(HDR_LEN_IDX);
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                // byte 0 is fetched here to keep page-to-page gaps short
                total_d     = hdr_total;
                trunc_d     = clamp;
                flags_d     = rd_flags;
                rd_en_c     = 1'b1;
                infl_d      = 1'b1;
                infl_last_d = (hdr_total == TW'(1));
                ptr_d       = TW'(1);
                state_d     = S_STREAM;
            end
            S_STREAM: begin
                if ((ptr_q < total_q) && (occ <= 3'd1)) begin
                    rd_en_c     = 1'b1;
                    addr_c      = ptr_q[A_WIDTH-1:0];
                    infl_d      = 1'b1;
                    infl_last_d = (ptr_q == total_q - TW'(1));
                    ptr_d       = ptr_q + TW'(1);
                end
                if (pop && skid_dout[8]) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                rd_done = 1'b1;
                state_d = S_IDLE;
            end
            S_FLUSH: begin
                rd_done_all = 1'b1;
                flush       = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_FLUSH;
            rd_en_c = 1'b0;
            infl_d  = 1'b0;
            flush   = 1'b1;
        end
    end

    assign rd_en   = rd_en_c && reset_n;
    assign rd_addr = rd_en ? addr_c : '0;

    // FSM and frame context registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            total_q     <= '0;
            flags_q     <= '0;
            trunc_q     <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            total_q     <= total_d;
            flags_q     <= flags_d;
            trunc_q     <= trunc_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
        end
    end

    cd_skid2 #(.W(SKID_W)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (flush),
        .push_i  (infl_q),
        .din_i   ({infl_last_q, rd_byte}),
        .ready_i (m.m_ready),
        .valid_o (skid_valid),
        .dout_o  (skid_dout),
        .count_o (skid_cnt)
    );

    assign m.m_valid = skid_valid;
    assign m.m_data  = skid_dout[7:0];
    assign m.m_last  = skid_dout[8];
    assign m.m_flags = flags_q;
    assign m.m_trunc = trunc_q;

endmodule

// File: tb/tb_cd_ram_drain.sv
// tb_cd_ram_drain: directed bench for cd_ram_drain
// RAM page model, stream monitor and per-scenario checks
module tb_cd_ram_drain;
    import cd_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       unread;
    logic       abort = 1'b0;
    logic [7:0] rd_addr;
    logic       rd_en;
    logic [7:0] rd_byte = 8'h00;
    logic [7:0] rd_flags = 8'h00;
    logic       rd_done;
    logic       rd_done_all;

    cd_ram_drain_if mif ();

    always #5 clk = ~clk;

    cd_ram_drain #(.A_WIDTH(8), .HDR_LEN_IDX(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .unread      (unread),
        .rd_addr     (rd_addr),
        .rd_en       (rd_en),
        .rd_byte     (rd_byte),
        .rd_flags    (rd_flags),
        .rd_done     (rd_done),
        .rd_done_all (rd_done_all),
        .abort       (abort),
        .m           (mif)
    );

    logic [7:0] pages [4][256];
    logic [7:0] pflags [4];
    int loaded = 0;
    int consumed = 0;
    int n_tests = 0;
    int n_fail = 0;

    assign unread = (loaded > consumed);

    logic [7:0] cap_d [$];
    bit         cap_l [$];
    logic [7:0] cap_f [$];
    bit         cap_t [$];
    int         cap_c [$];
    int         addr_log [$];
    int cyc = 0;
    int n_done = 0;
    int n_done_all = 0;
    int n_both = 0;
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [8:0] pd = 9'h0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [29:0] outs();
        return {rd_en, rd_done, rd_done_all, mif.m_valid, mif.m_last,
                mif.m_trunc, mif.m_flags, mif.m_data, rd_addr};
    endfunction

    // single-port page RAM with one cycle read latency
    always @(posedge clk) begin
        if (rd_en) begin
            rd_byte  <= pages[consumed % 4][rd_addr];
            rd_flags <= pflags[consumed % 4];
        end
    end

    // stream monitor: captures transfers, counts strobes, checks stall hold
    always @(negedge clk) begin
        cyc++;
        if (rd_en) addr_log.push_back(int'(rd_addr));
        if (rd_done && rd_done_all) n_both++;
        if (rd_done) begin
            n_done++;
            consumed++;
        end
        if (rd_done_all) begin
            n_done_all++;
            consumed = loaded;
        end
        if (reset_n && pv && !pr) begin
            check("hold_valid", 32'(mif.m_valid), 32'd1);
            check("hold_data", 32'({mif.m_last, mif.m_data}), 32'(pd));
        end
        if (mif.m_valid && mif.m_ready) begin
            cap_d.push_back(mif.m_data);
            cap_l.push_back(mif.m_last);
            cap_f.push_back(mif.m_flags);
            cap_t.push_back(mif.m_trunc);
            cap_c.push_back(cyc);
        end
        pv = mif.m_valid;
        pr = mif.m_ready;
        pd = {mif.m_last, mif.m_data};
    end

    task automatic load_page(input logic [7:0] len, input logic [7:0] fl,
                             output int p);
        p = loaded % 4;
        for (int a = 0; a < 256; a++) pages[p][a] = 8'(a * 7 + p * 29 + 1);
        pages[p][2] = len;
        pflags[p] = fl;
        loaded++;
    endtask

    task automatic run_until(input int target, input int budget,
                             input bit toggle, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (n_done >= target) break;
            if (toggle) mif.m_ready = ~mif.m_ready;
            tick();
        end
        check(tag, 32'(n_done), 32'(target));
    endtask

    task automatic check_frame(input int p, input int base, input int tot,
                               input logic [7:0] fl, input bit tr,
                               input string tag);
        int derr = 0;
        int lerr = 0;
        int ferr = 0;
        int n = cap_d.size() - base;
        if (n > tot) n = tot;
        check({tag, "_len"}, 32'(n), 32'(tot));
        for (int i = 0; i < n; i++) begin
            if (cap_d[base + i] !== pages[p][i]) derr++;
            if (cap_l[base + i] != (i == tot - 1)) lerr++;
            if (cap_f[base + i] !== fl || cap_t[base + i] != tr) ferr++;
        end
        check({tag, "_data"}, 32'(derr), 32'd0);
        check({tag, "_last"}, 32'(lerr), 32'd0);
        check({tag, "_flags"}, 32'(ferr), 32'd0);
    endtask

    initial begin
        int p, p2, base, d0, da, gap, aerr, t;
        mif.m_ready = 1'b0;
        repeat (3) tick();
        check("rst_outs", 32'(outs()), 32'd0);
        reset_n = 1'b1;
        tick();

        // len 4 -> 7 bytes at full rate
        base = cap_d.size();
        d0 = n_done;
        addr_log.delete();
        mif.m_ready = 1'b1;
        load_page(8'd4, 8'h5A, p);
        run_until(d0 + 1, 100, 1'b0, "A_done");
        repeat (3) tick();
        check("A_count", 32'(cap_d.size() - base), 32'd7);
        check_frame(p, base, 7, 8'h5A, 1'b0, "A");
        if (cap_d.size() - base >= 7)
            check("A_rate", 32'(cap_c[base + 6] - cap_c[base]), 32'd6);
        aerr = 0;
        if (addr_log.size() != 8) aerr++;
        else begin
            if (addr_log[0] != 2) aerr++;
            for (int i = 0; i < 7; i++) if (addr_log[i + 1] != i) aerr++;
        end
        check("A_addrs", 32'(aerr), 32'd0);
        check("A_pulses", 32'(n_done - d0), 32'd1);

        // same page with ready toggling
        base = cap_d.size();
        d0 = n_done;
        mif.m_ready = 1'b0;
        load_page(8'd4, 8'h5A, p);
        run_until(d0 + 1, 200, 1'b1, "B_done");
        mif.m_ready = 1'b1;
        repeat (3) tick();
        check("B_count", 32'(cap_d.size() - base), 32'd7);
        check_frame(p, base, 7, 8'h5A, 1'b0, "B");

        // len 0xFF clamps to a 256-byte truncated frame
        base = cap_d.size();
        d0 = n_done;
        load_page(8'hFF, 8'h11, p);
        run_until(d0 + 1, 400, 1'b0, "C_done");
        repeat (3) tick();
        check("C_count", 32'(cap_d.size() - base), 32'd256);
        check_frame(p, base, 256, 8'h11, 1'b1, "C");
        if (cap_d.size() - base >= 256)
            check("C_last_byte", 32'(cap_d[base + 255]), 32'(pages[p][255]));

        // two pages back to back
        base = cap_d.size();
        d0 = n_done;
        load_page(8'd1, 8'h22, p);
        load_page(8'd3, 8'h33, p2);
        run_until(d0 + 2, 200, 1'b0, "D_done");
        repeat (3) tick();
        check("D_count", 32'(cap_d.size() - base), 32'd10);
        check_frame(p, base, 4, 8'h22, 1'b0, "D1");
        check_frame(p2, base + 4, 6, 8'h33, 1'b0, "D2");
        if (cap_d.size() - base >= 5) begin
            gap = cap_c[base + 4] - cap_c[base + 3] - 1;
            check("D_gap_le3", 32'(gap <= 3), 32'd1);
        end

        // abort while the 3rd byte is presented
        base = cap_d.size();
        d0 = n_done;
        da = n_done_all;
        load_page(8'd4, 8'h44, p);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (mif.m_valid && cap_d.size() == base + 2) break;
        end
        check("E_at_byte3", 32'(cap_d.size() - base), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("E_valid_drop", 32'(mif.m_valid), 32'd0);
        check("E_done_all", 32'(rd_done_all), 32'd1);
        check("E_no_rd", 32'(rd_en), 32'd0);
        tick();
        check("E_idle", 32'(dut.state_q), 32'(S_IDLE));
        repeat (5) tick();
        check("E_all_once", 32'(n_done_all - da), 32'd1);
        check("E_no_done", 32'(n_done - d0), 32'd0);
        check("E_count", 32'(cap_d.size() - base), 32'd3);
        check("E_unread", 32'(unread), 32'd0);

        // reset during a stalled frame
        d0 = n_done;
        mif.m_ready = 1'b0;
        load_page(8'd4, 8'h66, p);
        t = 0;
        while (!mif.m_valid && t < 20) begin
            tick();
            t++;
        end
        check("F_streaming", 32'(mif.m_valid), 32'd1);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("F_rst_outs", 32'(outs()), 32'd0);
        tick();
        tick();
        check("F_no_done", 32'(n_done - d0), 32'd0);
        base = cap_d.size();
        addr_log.delete();
        mif.m_ready = 1'b1;
        reset_n = 1'b1;
        run_until(d0 + 1, 100, 1'b0, "F_done");
        repeat (3) tick();
        if (addr_log.size() > 0)
            check("F_hdr_addr", 32'(addr_log[0]), 32'd2);
        else
            check("F_hdr_addr", 32'hFFFF_FFFF, 32'd2);
        check("F_count", 32'(cap_d.size() - base), 32'd7);
        check_frame(p, base, 7, 8'h66, 1'b0, "F");

        check("no_both", 32'(n_both), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
